// File: rtl/learning_score_sequencer.sv
// Learning-mode song sequencer: fetches notes, lights the guide LED, judges presses (hit/miss/timeout).
// ROM read costs one FETCH plus one WAIT_DATA cycle; pulses and counts register one cycle after the judged edge; no backpressure.
module learning_score_sequencer #(
  parameter int IDX_W   = 6,
  parameter int TIMEOUT = 100_000_000,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       song_sel,
  input  logic [6:0]       key_in,
  output logic [IDX_W+3:0] rom_addr,
  input  logic [3:0]       rom_data,
  output logic [6:0]       expected_note,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] miss_count,
  output logic             busy,
  output logic             done
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_PROMPT,
    S_RELEASE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       song_latch_q, song_latch_d;
  logic [IDX_W-1:0] note_idx_q, note_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [6:0]       key_prev_q, key_prev_d;
  logic [6:0]       expected_note_q, expected_note_d;
  logic [IDX_W+3:0] rom_addr_q, rom_addr_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             miss_pulse_q, miss_pulse_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic       busy_now;
  logic [6:0] key_edge;
  logic       judged_hit;
  logic       judged_miss;

  assign busy_now = (state_q == S_FETCH) || (state_q == S_WAIT_DATA) ||
                    (state_q == S_PROMPT) || (state_q == S_RELEASE) ||
                    (state_q == S_ADVANCE);

  always_comb begin
    state_d         = state_q;
    song_latch_d    = song_latch_q;
    note_idx_d      = note_idx_q;
    timer_d         = timer_q;
    key_prev_d      = key_in;
    expected_note_d = expected_note_q;
    rom_addr_d      = rom_addr_q;
    score_d         = score_q;
    miss_count_d    = miss_count_q;
    hit_pulse_d     = 1'b0;
    miss_pulse_d    = 1'b0;
    judged_hit      = 1'b0;
    judged_miss     = 1'b0;
    key_edge        = key_in & ~key_prev_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          song_latch_d = song_sel;
          note_idx_d   = '0;
          score_d      = '0;
          miss_count_d = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if ((rom_data != 4'd0) && (rom_data <= 4'd7)) begin
          expected_note_d = 7'd1 << (rom_data - 4'd1);
          timer_d         = '0;
          state_d         = S_PROMPT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PROMPT: begin
        // A fresh key edge always beats a timeout landing in the same cycle.
        if (key_edge != 7'd0) begin
          if (key_edge == expected_note_q) begin
            judged_hit = 1'b1;
          end else begin
            judged_miss = 1'b1;
          end
          state_d = S_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          judged_miss = 1'b1;
          state_d     = S_ADVANCE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RELEASE: begin
        if (key_in == 7'd0) begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (note_idx_q == {IDX_W{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          note_idx_d = note_idx_q + IDX_W'(1);
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && busy_now) begin
      state_d     = S_IDLE;
      note_idx_d  = note_idx_q;
      judged_hit  = 1'b0;
      judged_miss = 1'b0;
    end

    // Address is presented for the whole FETCH cycle so a registered ROM has data ready in WAIT_DATA.
    if (state_d == S_FETCH) begin
      rom_addr_d = {song_latch_d, note_idx_d};
    end

    if (state_d != S_PROMPT) begin
      expected_note_d = 7'd0;
    end

    hit_pulse_d  = judged_hit;
    miss_pulse_d = judged_miss;
    if (judged_hit && (score_q != {CNT_W{1'b1}})) begin
      score_d = score_q + CNT_W'(1);
    end
    if (judged_miss && (miss_count_q != {CNT_W{1'b1}})) begin
      miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      song_latch_q    <= '0;
      note_idx_q      <= '0;
      timer_q         <= '0;
      key_prev_q      <= '0;
      expected_note_q <= '0;
      rom_addr_q      <= '0;
      hit_pulse_q     <= 1'b0;
      miss_pulse_q    <= 1'b0;
      score_q         <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      song_latch_q    <= song_latch_d;
      note_idx_q      <= note_idx_d;
      timer_q         <= timer_d;
      key_prev_q      <= key_prev_d;
      expected_note_q <= expected_note_d;
      rom_addr_q      <= rom_addr_d;
      hit_pulse_q     <= hit_pulse_d;
      miss_pulse_q    <= miss_pulse_d;
      score_q         <= score_d;
      miss_count_q    <= miss_count_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign expected_note = expected_note_q;
  assign hit_pulse     = hit_pulse_q;
  assign miss_pulse    = miss_pulse_q;
  assign score         = score_q;
  assign miss_count    = miss_count_q;
  assign busy          = busy_now;
  assign done          = (state_q == S_DONE);

endmodule
